// File: rtl/ibex_xif_offload_ctrl_if.sv
// ibex_xif_offload_ctrl_if
//   Extension-interface channels between the offload controller and the
//   accelerator: request (q), accept/writeback decision (k) and result (p).
//   master: offload controller side; slave: accelerator side.
//   q_*  request channel (valid/ready, instruction, operands, operand valids,
//        rd_clean)
//   k_*  decision, sampled together with the q handshake
//   p_*  response channel (valid/ready, rd, data, error)
interface ibex_xif_offload_ctrl_if;
  logic        q_valid;
  logic [31:0] q_instr_data;
  logic [31:0] q_rs1;
  logic [31:0] q_rs2;
  logic [31:0] q_rs3;
  logic [2:0]  q_rs_valid;
  logic        q_rd_clean;
  logic        q_ready;
  logic        k_writeback;
  logic        k_accept;
  logic        p_valid;
  logic [4:0]  p_rd;
  logic [31:0] p_data;
  logic        p_error;
  logic        p_ready;

  modport master (
    output q_valid, q_instr_data, q_rs1, q_rs2, q_rs3, q_rs_valid, q_rd_clean,
    input  q_ready, k_writeback, k_accept,
    input  p_valid, p_rd, p_data, p_error,
    output p_ready
  );

  modport slave (
    input  q_valid, q_instr_data, q_rs1, q_rs2, q_rs3, q_rs_valid, q_rd_clean,
    output q_ready, k_writeback, k_accept,
    output p_valid, p_rd, p_data, p_error,
    input  p_ready
  );
endinterface

// File: rtl/ibex_xif_offload_ctrl.sv
// ibex_xif_offload_ctrl
//   Offloads instructions from the ID stage to an external accelerator,
//   tracks in-flight register writebacks in a 32-entry scoreboard, stalls on
//   register hazards or when MaxOutstanding writebacks are pending, and
//   forwards accelerator results to the register-file write port.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   off_req_i, off_instr_i   offload request (held until off_done_o) and word
//   off_rs1_i..off_rs3_i     operand values
//   off_done_o/illegal_o     handshake-cycle pulse, rejected flag
//   off_stall_o              request blocked by hazard or full scoreboard
//   acc_x                    extension interface (master modport)
//   wb_valid_o/rd_o/data_o   registered register-file write
//   wb_err_o                 registered pulse: error or spurious response
//   perf_*_cnt_o             performance counters
//
// Build option
//   IBEX_XIF_PERF_CNT_EN  when defined, instantiates the offload/stall
//                         counters; otherwise both counter ports read 0.
//
// state | meaning
// IDLE  | no offload in progress
// STALL | offload waiting on a register hazard or a full scoreboard
// ISSUE | request presented on q, waiting for q_ready
module ibex_xif_offload_ctrl #(
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          TernaryOps     = 1'b0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           off_req_i,
  input  logic [31:0]                    off_instr_i,
  input  logic [31:0]                    off_rs1_i,
  input  logic [31:0]                    off_rs2_i,
  input  logic [31:0]                    off_rs3_i,
  output logic                           off_done_o,
  output logic                           off_illegal_o,
  output logic                           off_stall_o,
  ibex_xif_offload_ctrl_if.master        acc_x,
  output logic                           wb_valid_o,
  output logic [4:0]                     wb_rd_o,
  output logic [31:0]                    wb_data_o,
  output logic                           wb_err_o,
  output logic [31:0]                    perf_offload_cnt_o,
  output logic [31:0]                    perf_stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, STALL, ISSUE} state_e;

  state_e      state_q;
  logic [31:0] busy_q;   // bit 0 is never set: x0 has no writeback to wait on
  logic [31:0] busy_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;

  logic [4:0] rs1, rs2, rs3, rd;
  logic       issue, hazard, q_hs, sb_set, p_hit, p_spurious;

  assign rs1 = off_instr_i[19:15];
  assign rs2 = off_instr_i[24:20];
  assign rs3 = off_instr_i[31:27];
  assign rd  = off_instr_i[11:7];

  // rd is checked too (WAW) so that rd_clean can be promised on every request
  assign hazard = busy_q[rs1] | busy_q[rs2] | (TernaryOps & busy_q[rs3]) |
                  busy_q[rd] | (cnt_q == 4'(MaxOutstanding));

  assign issue  = (state_q == ISSUE);
  assign q_hs   = issue & acc_x.q_ready;
  assign sb_set = q_hs & acc_x.k_accept & acc_x.k_writeback & (rd != 5'd0);

  assign acc_x.q_valid      = issue;
  assign acc_x.q_instr_data = issue ? off_instr_i : '0;
  assign acc_x.q_rs1        = issue ? off_rs1_i : '0;
  assign acc_x.q_rs2        = issue ? off_rs2_i : '0;
  assign acc_x.q_rs3        = issue ? off_rs3_i : '0;
  assign acc_x.q_rs_valid   = issue ? {TernaryOps, 2'b11} : 3'b000;
  assign acc_x.q_rd_clean   = issue;

  assign off_done_o    = q_hs;
  assign off_illegal_o = q_hs & ~acc_x.k_accept;
  assign off_stall_o   = (state_q == STALL);

  assign acc_x.p_ready = (cnt_q != 4'd0);
  assign p_hit         = acc_x.p_valid & acc_x.p_ready & busy_q[acc_x.p_rd];
  // A response for a register nobody is waiting on (including anything that
  // arrives after a reset wiped the scoreboard) is flagged whether or not
  // p_ready happens to be high.
  assign p_spurious    = acc_x.p_valid & ~busy_q[acc_x.p_rd];

  // set and clear never hit the same rd: the WAW check keeps rd off the
  // request while it is still busy
  always_comb begin
    busy_d = busy_q;
    if (sb_set) busy_d[rd] = 1'b1;
    if (p_hit)  busy_d[acc_x.p_rd] = 1'b0;
    cnt_d = cnt_q;
    if (sb_set && !p_hit) cnt_d = cnt_q + 4'd1;
    if (!sb_set && p_hit) cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      busy_q     <= '0;
      cnt_q      <= '0;
      wb_valid_o <= 1'b0;
      wb_rd_o    <= '0;
      wb_data_o  <= '0;
      wb_err_o   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      wb_valid_o <= p_hit & ~acc_x.p_error;
      wb_rd_o    <= (p_hit & ~acc_x.p_error) ? acc_x.p_rd : 5'd0;
      wb_data_o  <= (p_hit & ~acc_x.p_error) ? acc_x.p_data : 32'd0;
      wb_err_o   <= (p_hit & acc_x.p_error) | p_spurious;
      unique case (state_q)
        IDLE:    if (off_req_i) state_q <= hazard ? STALL : ISSUE;
        STALL: begin
          if (!off_req_i)   state_q <= IDLE;
          else if (!hazard) state_q <= ISSUE;
        end
        // a completed handshake wins over a dropped request
        ISSUE:   if (q_hs || !off_req_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IBEX_XIF_PERF_CNT_EN
  logic [31:0] perf_off_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_off_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (q_hs && acc_x.k_accept) perf_off_q <= perf_off_q + 32'd1;
      if (state_q == STALL)       perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_offload_cnt_o = perf_off_q;
  assign perf_stall_cnt_o   = perf_stall_q;
`else
  assign perf_offload_cnt_o = '0;
  assign perf_stall_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_ibex_xif_offload_ctrl.sv
// tb_ibex_xif_offload_ctrl
//   Self-checking bench for ibex_xif_offload_ctrl built with MaxOutstanding=2
//   and TernaryOps=0. A transaction-level model (busy bitmap, pending count,
//   expected counter values) predicts every checked output.
module tb_ibex_xif_offload_ctrl;
  localparam int MAX = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        off_req;
  logic [31:0] off_instr, off_rs1, off_rs2, off_rs3;
  logic        off_done, off_illegal, off_stall;
  logic        wb_valid, wb_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, perf_off, perf_stall;

  ibex_xif_offload_ctrl_if acc_x();

  ibex_xif_offload_ctrl #(.MaxOutstanding(MAX), .TernaryOps(1'b0)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .off_req_i          (off_req),
    .off_instr_i        (off_instr),
    .off_rs1_i          (off_rs1),
    .off_rs2_i          (off_rs2),
    .off_rs3_i          (off_rs3),
    .off_done_o         (off_done),
    .off_illegal_o      (off_illegal),
    .off_stall_o        (off_stall),
    .acc_x              (acc_x.master),
    .wb_valid_o         (wb_valid),
    .wb_rd_o            (wb_rd),
    .wb_data_o          (wb_data),
    .wb_err_o           (wb_err),
    .perf_offload_cnt_o (perf_off),
    .perf_stall_cnt_o   (perf_stall)
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference model
  bit [31:0] mb;
  int        mc;
  int        exp_off;
  int        exp_stall;

  typedef struct {
    logic [31:0] instr;
    bit          acc;
    bit          wbk;
    logic [4:0]  p_rd;
    logic [31:0] data;
    bit          err;
    bit          exp_ill;
    bit          exp_wbv;
    bit          exp_err;
  } vec_t;

  vec_t tbl [5];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_done"}, off_done, 1'b0);
    chk1({tag, "_illegal"}, off_illegal, 1'b0);
    chk1({tag, "_stall"}, off_stall, 1'b0);
    chk1({tag, "_q_valid"}, acc_x.q_valid, 1'b0);
    chk32({tag, "_q_instr"}, acc_x.q_instr_data, 32'd0);
    chk32({tag, "_q_rs1"}, acc_x.q_rs1, 32'd0);
    chk32({tag, "_q_rs2"}, acc_x.q_rs2, 32'd0);
    chk32({tag, "_q_rs3"}, acc_x.q_rs3, 32'd0);
    chk32({tag, "_q_rs_valid"}, 32'(acc_x.q_rs_valid), 32'd0);
    chk1({tag, "_q_rd_clean"}, acc_x.q_rd_clean, 1'b0);
    chk1({tag, "_p_ready"}, acc_x.p_ready, 1'b0);
    chk1({tag, "_wb_valid"}, wb_valid, 1'b0);
    chk32({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk32({tag, "_wb_data"}, wb_data, 32'd0);
    chk1({tag, "_wb_err"}, wb_err, 1'b0);
    chk32({tag, "_perf_off"}, perf_off, 32'd0);
    chk32({tag, "_perf_stall"}, perf_stall, 32'd0);
  endtask

  function automatic bit model_hazard(input logic [31:0] instr);
    // rs3 is not a source operand with TernaryOps=0
    return mb[instr[19:15]] | mb[instr[24:20]] | mb[instr[11:7]] | (mc == MAX);
  endfunction

  // Starts and ends at a sample point with the controller idle.
  task automatic offload(input logic [31:0] instr, input bit acc, input bit wbk,
                         input int hold, output bit ill_obs);
    logic [31:0] v1, v2, v3;
    logic [4:0]  rd;
    bit          haz;
    rd  = instr[11:7];
    v1  = $urandom;
    v2  = $urandom;
    v3  = $urandom;
    haz = model_hazard(instr);
    ill_obs = 1'b0;
    off_req = 1'b1; off_instr = instr; off_rs1 = v1; off_rs2 = v2; off_rs3 = v3;
    #1;
    chk1("idle_q_valid", acc_x.q_valid, 1'b0);
    cyc();
    if (haz) begin
      chk1("haz_stall", off_stall, 1'b1);
      chk1("haz_q_valid", acc_x.q_valid, 1'b0);
      exp_stall++;
      cyc();
      chk1("haz_stall_hold", off_stall, 1'b1);
      exp_stall++;
      off_req = 1'b0;
      cyc();
      chk1("haz_abandon", off_stall, 1'b0);
      chk1("haz_abandon_q_valid", acc_x.q_valid, 1'b0);
    end else begin
      chk1("issue_q_valid", acc_x.q_valid, 1'b1);
      chk1("issue_stall", off_stall, 1'b0);
      chk32("issue_instr", acc_x.q_instr_data, instr);
      chk32("issue_rs1", acc_x.q_rs1, v1);
      chk32("issue_rs2", acc_x.q_rs2, v2);
      chk32("issue_rs3", acc_x.q_rs3, v3);
      chk32("issue_rs_valid", 32'(acc_x.q_rs_valid), 32'd3);
      chk1("issue_rd_clean", acc_x.q_rd_clean, 1'b1);
      for (int i = 0; i < hold; i++) begin
        chk1("wait_done", off_done, 1'b0);
        cyc();
        chk1("wait_q_valid", acc_x.q_valid, 1'b1);
        chk32("wait_instr_stable", acc_x.q_instr_data, instr);
      end
      acc_x.q_ready = 1'b1; acc_x.k_accept = acc; acc_x.k_writeback = wbk;
      #1;
      chk1("hs_done", off_done, 1'b1);
      chk1("hs_illegal", off_illegal, !acc);
      ill_obs = off_illegal;
      cyc();
      acc_x.q_ready = 1'b0; acc_x.k_accept = 1'b0; acc_x.k_writeback = 1'b0;
      off_req = 1'b0;
      if (acc) exp_off++;
      if (acc && wbk && rd != 5'd0) begin
        mb[rd] = 1'b1;
        mc++;
      end
      chk1("post_q_valid", acc_x.q_valid, 1'b0);
      chk1("post_done", off_done, 1'b0);
      chk1("post_p_ready", acc_x.p_ready, mc != 0);
    end
  endtask

  task automatic respond(input logic [4:0] rd, input logic [31:0] data, input bit err,
                         output bit wbv_obs, output bit err_obs);
    bit hit;
    hit = mb[rd];
    acc_x.p_valid = 1'b1; acc_x.p_rd = rd; acc_x.p_data = data; acc_x.p_error = err;
    #1;
    chk1("resp_p_ready", acc_x.p_ready, mc != 0);
    cyc();
    acc_x.p_valid = 1'b0; acc_x.p_error = 1'b0;
    if (hit) begin
      mb[rd] = 1'b0;
      mc--;
    end
    chk1("resp_wb_valid", wb_valid, hit && !err);
    chk32("resp_wb_rd", 32'(wb_rd), (hit && !err) ? 32'(rd) : 32'd0);
    chk32("resp_wb_data", wb_data, (hit && !err) ? data : 32'd0);
    chk1("resp_wb_err", wb_err, (hit && err) || !hit);
    chk1("resp_cnt", acc_x.p_ready, mc != 0);
    wbv_obs = wb_valid;
    err_obs = wb_err;
    cyc();
    chk1("resp_wb_valid_pulse", wb_valid, 1'b0);
    chk1("resp_wb_err_pulse", wb_err, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ill, wbv, er;
    logic [4:0] r;
    mb = '0; mc = 0; exp_off = 0; exp_stall = 0;
    off_req = 1'b0; off_instr = '0; off_rs1 = '0; off_rs2 = '0; off_rs3 = '0;
    acc_x.q_ready = 1'b0; acc_x.k_accept = 1'b0; acc_x.k_writeback = 1'b0;
    acc_x.p_valid = 1'b0; acc_x.p_rd = '0; acc_x.p_data = '0; acc_x.p_error = 1'b0;

    tbl[0] = '{32'h0000_B50B, 1'b1, 1'b1, 5'd10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{32'h0000_B50B, 1'b0, 1'b1, 5'd10, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h0000_000B, 1'b1, 1'b1, 5'd0,  32'hCAFE_0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{32'h0000_028B, 1'b1, 1'b0, 5'd5,  32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{32'h0000_0F8B, 1'b1, 1'b1, 5'd31, 32'hA5A5_5A5A, 1'b0, 1'b0, 1'b1, 1'b0};

    #1;
    chk_all_zero("reset");
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk_all_zero("post_reset");

    // table: one offload followed by one response per row
    for (int i = 0; i < 5; i++) begin
      offload(tbl[i].instr, tbl[i].acc, tbl[i].wbk, i % 3, ill);
      chk1("tbl_illegal", ill, tbl[i].exp_ill);
      respond(tbl[i].p_rd, tbl[i].data, tbl[i].err, wbv, er);
      chk1("tbl_wb_valid", wbv, tbl[i].exp_wbv);
      chk1("tbl_wb_err", er, tbl[i].exp_err);
    end

    // RAW hazard on rd=5, released by its response
    offload(32'h0000_028B, 1'b1, 1'b1, 0, ill);
    off_req = 1'b1; off_instr = 32'h0002_848B;  // rs1=5 rd=9
    cyc();
    chk1("raw_stall0", off_stall, 1'b1); exp_stall++;
    cyc();
    chk1("raw_stall1", off_stall, 1'b1); exp_stall++;
    acc_x.p_valid = 1'b1; acc_x.p_rd = 5'd5; acc_x.p_data = 32'h0BAD_F00D;
    cyc();
    acc_x.p_valid = 1'b0;
    mb[5] = 1'b0; mc--;
    chk1("raw_stall_after_clear", off_stall, 1'b1); exp_stall++;
    chk1("raw_no_valid_yet", acc_x.q_valid, 1'b0);
    chk1("raw_wb_valid", wb_valid, 1'b1);
    chk32("raw_wb_data", wb_data, 32'h0BAD_F00D);
    cyc();
    chk1("raw_issue", acc_x.q_valid, 1'b1);
    chk1("raw_issue_stall", off_stall, 1'b0);
    acc_x.q_ready = 1'b1; acc_x.k_accept = 1'b1; acc_x.k_writeback = 1'b0;
    #1;
    chk1("raw_done", off_done, 1'b1);
    cyc();
    acc_x.q_ready = 1'b0; acc_x.k_accept = 1'b0; off_req = 1'b0; exp_off++;

    // outstanding limit: rd=3, rd=4 pending, rd=6 waits for a response
    offload(32'h0000_018B, 1'b1, 1'b1, 0, ill);
    offload(32'h0000_020B, 1'b1, 1'b1, 1, ill);
    off_req = 1'b1; off_instr = 32'h0000_030B;
    cyc();
    chk1("full_stall0", off_stall, 1'b1); exp_stall++;
    cyc();
    chk1("full_stall1", off_stall, 1'b1); exp_stall++;
    acc_x.p_valid = 1'b1; acc_x.p_rd = 5'd3; acc_x.p_data = 32'h3333_3333;
    cyc();
    acc_x.p_valid = 1'b0;
    mb[3] = 1'b0; mc--;
    chk1("full_stall2", off_stall, 1'b1); exp_stall++;
    chk32("full_wb_rd", 32'(wb_rd), 32'd3);
    cyc();
    chk1("full_issue", acc_x.q_valid, 1'b1);
    acc_x.q_ready = 1'b1; acc_x.k_accept = 1'b1; acc_x.k_writeback = 1'b1;
    #1;
    chk1("full_done", off_done, 1'b1);
    cyc();
    acc_x.q_ready = 1'b0; acc_x.k_accept = 1'b0; acc_x.k_writeback = 1'b0; off_req = 1'b0;
    exp_off++; mb[6] = 1'b1; mc++;
    respond(5'd4, 32'h4444_4444, 1'b0, wbv, er);
    respond(5'd6, 32'h6666_6666, 1'b0, wbv, er);

    // spurious response with one pending, then an error response
    offload(32'h0000_060B, 1'b1, 1'b1, 0, ill);  // rd=12
    respond(5'd7, 32'h7777_7777, 1'b0, wbv, er);
    chk1("spur_still_pending", acc_x.p_ready, 1'b1);
    respond(5'd12, 32'hEEEE_EEEE, 1'b1, wbv, er);
    chk1("err_cleared", acc_x.p_ready, 1'b0);

    // randomized traffic
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        logic [31:0] instr;
        instr = {2'b00, 3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7)),
                 2'b00, 3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7)),
                 3'b000, 2'b00, 3'($urandom_range(0, 7)), 7'h0B};
        offload(instr, $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2), ill);
      end else begin
        r = 5'($urandom_range(0, 7));
        if (mc != 0 && $urandom_range(0, 3) != 0) begin
          for (int k = 1; k < 32; k++) if (mb[k]) r = 5'(k);
        end
        respond(r, $urandom, $urandom_range(0, 4) == 0, wbv, er);
      end
    end

`ifdef IBEX_XIF_PERF_CNT_EN
    chk32("perf_offload", perf_off, 32'(exp_off));
    chk32("perf_stall", perf_stall, 32'(exp_stall));
`else
    chk32("perf_offload_tied", perf_off, 32'd0);
    chk32("perf_stall_tied", perf_stall, 32'd0);
`endif

    // reset with a writeback pending and a request on q
    while (mc != 0) begin
      for (int k = 1; k < 32; k++) if (mb[k]) r = 5'(k);
      respond(r, 32'h0, 1'b0, wbv, er);
    end
    offload(32'h0000_018B, 1'b1, 1'b1, 0, ill);
    off_req = 1'b1; off_instr = 32'h0000_048B;
    cyc();
    chk1("rst_pre_q_valid", acc_x.q_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    off_req = 1'b0;
    mb = '0; mc = 0; exp_off = 0; exp_stall = 0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk_all_zero("after_mid_reset");
    respond(5'd3, 32'h3030_3030, 1'b0, wbv, er);
    chk1("late_resp_spurious", er, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
